// File: rtl/led_matrix_pkg.sv
// Shared definitions for the LED dot-matrix scroller: display modes,
// default panel geometry and the stored glyph bitmaps.
package led_matrix_pkg;

  typedef enum logic {
    MODE_STATIC = 1'b0,
    MODE_SCROLL = 1'b1
  } mode_e;

  localparam int ROWS = 16;
  localparam int COLS = 16;

  // Number of glyphs physically present in GLYPH_BITMAP.
  localparam int N_GLYPH_STORED = 3;

  // Column-major bitmaps: word [g*COLS + c] is column c of glyph g,
  // bit ROWS-1 is the top pixel.
  localparam logic [ROWS-1:0] GLYPH_BITMAP [N_GLYPH_STORED*COLS] = '{
    16'h8001, 16'hC003, 16'hE007, 16'hF00F, 16'hF81F, 16'hFC3F, 16'hFE7F, 16'hFFFF,
    16'h7FFE, 16'h3FFC, 16'h1FF8, 16'h0FF0, 16'h07E0, 16'h03C0, 16'h0180, 16'h1111,
    16'h0F0F, 16'h1E1E, 16'h3C3C, 16'h7878, 16'hF0F0, 16'hE1E1, 16'hC3C3, 16'h8787,
    16'h1234, 16'h2345, 16'h3456, 16'h4567, 16'h5678, 16'h6789, 16'h789A, 16'h89AB,
    16'hAAAA, 16'h5555, 16'hA5A5, 16'h5A5A, 16'hFF00, 16'h00FF, 16'hABCD, 16'hDCBA,
    16'hCCCC, 16'h3333, 16'hC3C3, 16'h3C3C, 16'h9999, 16'h6666, 16'h9696, 16'h6969
  };

  // The blank glyph always sits just past the last real glyph.
  function automatic int blank_idx(input int n_glyph);
    return n_glyph;
  endfunction

endpackage

// File: rtl/led_matrix_scroller_glyph_rom.sv
// Combinational glyph ROM: (glyph, column) -> pixel word, blank past the glyph set.
module glyph_rom #(
  parameter int N_GLYPH = 3,
  parameter int ROWS    = led_matrix_pkg::ROWS,
  parameter int COLS    = led_matrix_pkg::COLS
) (
  input  logic [$clog2(N_GLYPH+1)-1:0] g,
  input  logic [$clog2(COLS)-1:0]      c,
  output logic [ROWS-1:0]              word
);
  import led_matrix_pkg::*;

  localparam int STORED_COLS  = led_matrix_pkg::COLS;
  localparam int STORED_WORDS = N_GLYPH_STORED * STORED_COLS;
  localparam int IW           = $clog2(STORED_WORDS);

  logic [IW-1:0] idx;

  // Look up the stored column; anything outside the stored set reads dark.
  always_comb begin
    word = '0;
    idx  = '0;
    if (int'(g) < N_GLYPH && int'(g) < N_GLYPH_STORED && int'(c) < STORED_COLS) begin
      idx  = IW'(int'(g) * STORED_COLS + int'(c));
      word = ROWS'(GLYPH_BITMAP[idx]);
    end
  end

endmodule

// File: rtl/led_matrix_scroller.sv
// Column-scan driver for the LED dot-matrix: static glyph cycling or
// right-to-left scroll, with all state committed only at frame boundaries.
module led_matrix_scroller #(
  parameter int N_GLYPH       = 3,
  parameter int ROWS          = led_matrix_pkg::ROWS,
  parameter int COLS          = led_matrix_pkg::COLS,
  parameter int DWELL_FRAMES  = 64,
  parameter int SCROLL_FRAMES = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic                         mode,
  output logic [ROWS-1:0]              row,
  output logic [$clog2(COLS)-1:0]      line,
  output logic [$clog2(N_GLYPH+1)-1:0] glyph_idx,
  output logic                         frame_done
);
  import led_matrix_pkg::*;

  localparam int CW        = $clog2(COLS);
  localparam int GW        = $clog2(N_GLYPH+1);
  localparam int STRIP_LEN = (N_GLYPH + 1) * COLS;
  localparam int OW        = $clog2(STRIP_LEN);
  localparam int FRAME_MAX = (DWELL_FRAMES > SCROLL_FRAMES) ? DWELL_FRAMES : SCROLL_FRAMES;
  localparam int FW        = $clog2(FRAME_MAX) + 1;

  logic [CW-1:0]   col_q, col_d;
  logic [CW-1:0]   line_q, line_d;
  logic [ROWS-1:0] row_q, row_d;
  logic [GW-1:0]   glyph_q, glyph_d;
  logic [OW-1:0]   offset_q, offset_d;
  logic [FW-1:0]   cnt_q, cnt_d;
  mode_e           mode_q, mode_d;
  logic            started_q, started_d;
  logic            frame_done_q, frame_done_d;

  logic            boundary;
  logic [OW:0]     strip_sum;
  logic [OW-1:0]   strip_col;
  logic [GW-1:0]   sel_g;
  logic [CW-1:0]   sel_c;
  logic [ROWS-1:0] rom_word;

  // The very first column 0 after reset opens the first frame rather than ending one.
  assign boundary = en && (col_q == '0) && started_q;

  // Scan counter and frame-boundary commit of mode, dwell/scroll count, glyph and offset.
  always_comb begin
    col_d     = col_q;
    started_d = started_q;
    mode_d    = mode_q;
    glyph_d   = glyph_q;
    offset_d  = offset_q;
    cnt_d     = cnt_q;
    if (en) begin
      col_d     = col_q + CW'(1);
      started_d = 1'b1;
    end
    if (boundary) begin
      if (mode_e'(mode) != mode_q) begin
        mode_d   = mode_e'(mode);
        glyph_d  = '0;
        offset_d = '0;
        cnt_d    = '0;
      end else if (mode_q == MODE_STATIC) begin
        if (cnt_q == FW'(DWELL_FRAMES - 1)) begin
          cnt_d   = '0;
          glyph_d = (glyph_q == GW'(blank_idx(N_GLYPH))) ? '0 : glyph_q + GW'(1);
        end else begin
          cnt_d = cnt_q + FW'(1);
        end
      end else begin
        if (cnt_q == FW'(SCROLL_FRAMES - 1)) begin
          cnt_d    = '0;
          offset_d = (offset_q == OW'(STRIP_LEN - 1)) ? '0 : offset_q + OW'(1);
        end else begin
          cnt_d = cnt_q + FW'(1);
        end
        glyph_d = GW'(offset_d >> CW);
      end
    end
  end

  // Pick the ROM address for the column being loaded, using the state this edge commits.
  always_comb begin
    strip_sum = {1'b0, offset_d} + (OW+1)'(col_q);
    if (strip_sum >= (OW+1)'(STRIP_LEN)) begin
      strip_col = OW'(strip_sum - (OW+1)'(STRIP_LEN));
    end else begin
      strip_col = OW'(strip_sum);
    end
    if (mode_d == MODE_STATIC) begin
      sel_g = glyph_d;
      sel_c = col_q;
    end else begin
      sel_g = GW'(strip_col >> CW);
      sel_c = CW'(strip_col);
    end
  end

  glyph_rom #(
    .N_GLYPH (N_GLYPH),
    .ROWS    (ROWS),
    .COLS    (COLS)
  ) u_rom (
    .g    (sel_g),
    .c    (sel_c),
    .word (rom_word)
  );

  // Output words: panel goes dark and the address holds while scanning is disabled.
  always_comb begin
    line_d       = en ? col_q : line_q;
    row_d        = en ? rom_word : '0;
    frame_done_d = en && (col_q == CW'(COLS - 1));
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q        <= '0;
      line_q       <= '0;
      row_q        <= '0;
      glyph_q      <= '0;
      offset_q     <= '0;
      cnt_q        <= '0;
      mode_q       <= MODE_STATIC;
      started_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      line_q       <= line_d;
      row_q        <= row_d;
      glyph_q      <= glyph_d;
      offset_q     <= offset_d;
      cnt_q        <= cnt_d;
      mode_q       <= mode_d;
      started_q    <= started_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign row        = row_q;
  assign line       = line_q;
  assign glyph_idx  = glyph_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_led_matrix_scroller.sv
// Self-checking bench for led_matrix_scroller: a frame-count reference model
// feeds a scoreboard queue, driven by a phase table plus hand-written corner sequences.
module tb_led_matrix_scroller;
  import led_matrix_pkg::*;

  localparam int NG    = 3;
  localparam int RW    = 16;
  localparam int CL    = 16;
  localparam int DW    = 2;
  localparam int SF    = 1;
  localparam int STRIP = (NG + 1) * CL;
  localparam int LW    = $clog2(CL);
  localparam int GW    = $clog2(NG + 1);

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          en    = 1'b0;
  logic          mode  = 1'b0;
  logic [RW-1:0] row;
  logic [LW-1:0] line;
  logic [GW-1:0] glyph_idx;
  logic          frame_done;

  led_matrix_scroller #(
    .N_GLYPH       (NG),
    .ROWS          (RW),
    .COLS          (CL),
    .DWELL_FRAMES  (DW),
    .SCROLL_FRAMES (SF)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .mode       (mode),
    .row        (row),
    .line       (line),
    .glyph_idx  (glyph_idx),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   row;
    int   line;
    int   glyph;
    logic fd;
  } exp_t;

  typedef struct {
    logic en;
    logic mode;
    int   cycles;
    int   exp_glyph_end;
  } phase_t;

  exp_t   sb[$];
  phase_t phases[3];

  int assertions = 0;
  int failures   = 0;

  // Reference model state: frames counted since the current mode was latched.
  int   m_col, m_line, m_glyph, m_frames;
  logic m_mode, m_started;

  function automatic int romRef(input int g, input int c);
    if (g >= NG) return 0;
    return int'(GLYPH_BITMAP[g * CL + c]);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    assertions++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_col = 0; m_line = 0; m_glyph = 0; m_frames = 0;
    m_mode = 1'b0; m_started = 1'b0;
    sb.delete();
  endtask

  task automatic modelStep(input logic e, input logic md);
    exp_t x;
    int pos, s;
    if (!e) begin
      x.row = 0; x.line = m_line; x.glyph = m_glyph; x.fd = 1'b0;
    end else begin
      if (m_col == 0 && m_started) begin
        if (md != m_mode) begin
          m_mode   = md;
          m_frames = 0;
        end else begin
          m_frames++;
        end
      end
      m_started = 1'b1;
      if (m_mode) begin
        pos     = (m_frames / SF) % STRIP;
        m_glyph = pos / CL;
        s       = (pos + m_col) % STRIP;
        x.row   = romRef(s / CL, s % CL);
      end else begin
        m_glyph = (m_frames / DW) % (NG + 1);
        x.row   = romRef(m_glyph, m_col);
      end
      m_line  = m_col;
      x.line  = m_col;
      x.glyph = m_glyph;
      x.fd    = (m_col == CL - 1);
      m_col   = (m_col + 1) % CL;
    end
    sb.push_back(x);
  endtask

  task automatic checkOutput();
    exp_t x;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 0, 1);
    end else begin
      x = sb.pop_front();
      check("row", int'(row), x.row);
      check("line", int'(line), x.line);
      check("glyph_idx", int'(glyph_idx), x.glyph);
      check("frame_done", int'(frame_done), int'(x.fd));
    end
  endtask

  task automatic applyStimulus(input logic e, input logic md);
    en   = e;
    mode = md;
    modelStep(e, md);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic waitLine(input int target, input logic e, input logic md);
    int n;
    n = 0;
    do begin
      applyStimulus(e, md);
      n++;
    end while (int'(line) != target && n < 4 * CL);
    check("wait_line", int'(line), target);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int held;

    phases[0] = '{en: 1'b1, mode: 1'b0, cycles: 200, exp_glyph_end: 2};
    phases[1] = '{en: 1'b0, mode: 1'b0, cycles: 5,   exp_glyph_end: 2};
    phases[2] = '{en: 1'b1, mode: 1'b0, cycles: 40,  exp_glyph_end: 3};

    modelReset();
    #12;
    check("reset_row", int'(row), 0);
    check("reset_line", int'(line), 0);
    check("reset_glyph", int'(glyph_idx), 0);
    check("reset_fd", int'(frame_done), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("[TB] static phases");
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < phases[p].cycles; k++) begin
        applyStimulus(phases[p].en, phases[p].mode);
      end
      check("phase_glyph_end", int'(glyph_idx), phases[p].exp_glyph_end);
    end

    $display("[TB] mode change mid-frame");
    waitLine(5, 1'b1, 1'b0);
    held = m_glyph;
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b1, 1'b1);
      check("mc_glyph_hold", int'(glyph_idx), held);
    end
    applyStimulus(1'b1, 1'b1);
    check("mc_line_zero", int'(line), 0);
    check("mc_glyph_zero", int'(glyph_idx), 0);
    check("mc_row_first", int'(row), romRef(0, 0));

    $display("[TB] scroll through full strip");
    for (int k = 1; k < 65 * CL; k++) begin
      applyStimulus(1'b1, 1'b1);
      if (k == CL) check("scroll_f1_c0", int'(row), romRef(0, 1));
      if (k == 16 * CL) check("scroll_f16_c0", int'(row), romRef(1, 0));
      if (k == 48 * CL) check("scroll_blank", int'(row), 0);
      if (k >= 64 * CL) check("scroll_wrap", int'(row), romRef(0, k - 64 * CL));
      if (k == 64 * CL) check("scroll_wrap_glyph", int'(glyph_idx), 0);
    end

    $display("[TB] enable drop");
    waitLine(7, 1'b1, 1'b1);
    held = m_glyph;
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b0, 1'b1);
      check("en_row_dark", int'(row), 0);
      check("en_line_hold", int'(line), 7);
      check("en_fd_low", int'(frame_done), 0);
    end
    applyStimulus(1'b1, 1'b1);
    check("en_resume_line", int'(line), 8);
    check("en_resume_glyph", int'(glyph_idx), held);

    $display("[TB] reset mid-frame in scroll mode");
    waitLine(9, 1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_row", int'(row), 0);
    check("arst_line", int'(line), 0);
    check("arst_glyph", int'(glyph_idx), 0);
    check("arst_fd", int'(frame_done), 0);
    modelReset();
    @(posedge clk);
    #1;
    mode  = 1'b0;
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0);
    check("post_rst_line", int'(line), 0);
    check("post_rst_row", int'(row), romRef(0, 0));
    for (int k = 1; k < 80; k++) begin
      applyStimulus(1'b1, 1'b0);
    end
    check("post_rst_glyph", int'(glyph_idx), 2);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
